// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared WS2812 timing constants, receiver states and byte ordering
//
// Contents:
//   cycles_ns          nanoseconds -> clock cycles at a given clock frequency
//   t0h/t1h/bit_thresh/min_high/max_high/reset_gap_cycles
//                      pulse-timing constants in cycles; the transmitter and
//                      receiver both derive their timing from these functions
//   rx_state_t, ST_*   receiver FSM state encoding
//   data_to_wire / wire_to_data
//                      byte reorder between data-field order and wire order

package ws2812_pkg;

  typedef logic [1:0] rx_state_t;

  localparam rx_state_t ST_UNSYNC = 2'd0;
  localparam rx_state_t ST_IDLE   = 2'd1;
  localparam rx_state_t ST_HIGH   = 2'd2;
  localparam rx_state_t ST_LOW    = 2'd3;

  // 64-bit intermediate so fast clocks do not overflow the product.
  function automatic int cycles_ns(input int clk_freq, input int ns);
    return int'((longint'(clk_freq) * longint'(ns)) / longint'(1000000000));
  endfunction

  function automatic int t0h_cycles(input int clk_freq);
    return cycles_ns(clk_freq, 350);
  endfunction

  function automatic int t1h_cycles(input int clk_freq);
    return cycles_ns(clk_freq, 700);
  endfunction

  function automatic int bit_thresh_cycles(input int clk_freq);
    return cycles_ns(clk_freq, 600);
  endfunction

  function automatic int min_high_cycles(input int clk_freq);
    return cycles_ns(clk_freq, 100);
  endfunction

  function automatic int max_high_cycles(input int clk_freq);
    return cycles_ns(clk_freq, 2000);
  endfunction

  function automatic int reset_gap_cycles(input int clk_freq);
    return clk_freq / 20000;
  endfunction

  // The transmitter swaps the two upper bytes of the data field onto the
  // wire (G/R swap). The swap is its own inverse, so both directions share it.
  function automatic logic [23:0] data_to_wire(input logic [23:0] d);
    return {d[15:8], d[23:16], d[7:0]};
  endfunction

  function automatic logic [23:0] wire_to_data(input logic [23:0] w);
    return {w[15:8], w[23:16], w[7:0]};
  endfunction

endpackage

// File: rtl/ws2812_pulse_meter.sv
// rtl/ws2812_pulse_meter.sv - synchronizes the WS2812 line and measures high/low pulse widths
//
// Ports:
//   clock      in   system clock
//   reset      in   synchronous active-high reset
//   din        in   raw serial line, asynchronous to clock
//   rise       out  synchronized line went low -> high this cycle
//   bit_valid  out  a legal-width high pulse ended this cycle
//   bit_val    out  decoded value of that pulse (width >= BIT_THRESH)
//   glitch     out  a high pulse shorter than MIN_HIGH ended this cycle
//   too_long   out  the current/just-ended high pulse exceeded MAX_HIGH
//   gap        out  line has been low for RESET_GAP cycles (latch)

module ws2812_pulse_meter #(
  parameter int MIN_HIGH   = 2,
  parameter int BIT_THRESH = 12,
  parameter int MAX_HIGH   = 40,
  parameter int RESET_GAP  = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic bit_valid,
  output logic bit_val,
  output logic glitch,
  output logic too_long,
  output logic gap
);

  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int LW = $clog2(RESET_GAP + 1);

  localparam logic [HW-1:0] HI_MIN = HW'(MIN_HIGH);
  localparam logic [HW-1:0] HI_THR = HW'(BIT_THRESH);
  localparam logic [HW-1:0] HI_MAX = HW'(MAX_HIGH);
  localparam logic [HW-1:0] HI_SAT = HW'(MAX_HIGH + 1);
  localparam logic [LW-1:0] LO_SAT = LW'(RESET_GAP);

  logic [1:0]    sync;
  logic          din_s;
  logic          din_d;
  logic          fall;
  logic [HW-1:0] hi_cnt;
  logic [LW-1:0] lo_cnt;

  assign din_s = sync[1];
  assign rise  = din_s & ~din_d;
  assign fall  = din_d & ~din_s;

  // Counters restart at 1 on the edge so the count includes the edge cycle;
  // on the fall cycle hi_cnt therefore equals the full high width.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync   <= '0;
      din_d  <= 1'b0;
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else begin
      sync  <= {sync[0], din};
      din_d <= din_s;
      if (din_s) begin
        lo_cnt <= '0;
        if (rise)
          hi_cnt <= HW'(1);
        else if (hi_cnt != HI_SAT)
          hi_cnt <= hi_cnt + HW'(1);
      end else begin
        if (fall)
          lo_cnt <= LW'(1);
        else if (lo_cnt != LO_SAT)
          lo_cnt <= lo_cnt + LW'(1);
      end
    end
  end

  // din_d also covers the fall cycle, so a pulse that ends exactly as it
  // crosses MAX_HIGH is still flagged rather than decoded as a 1.
  assign too_long  = din_d & (hi_cnt > HI_MAX);
  assign glitch    = fall & (hi_cnt < HI_MIN);
  assign bit_valid = fall & ~glitch & ~too_long;
  assign bit_val   = (hi_cnt >= HI_THR);
  assign gap       = (lo_cnt == LO_SAT);

endmodule

// File: rtl/ws2812_rx.sv
// rtl/ws2812_rx.sv - WS2812 receive decoder: pixels, indices, frame boundaries, errors
//
// Ports:
//   clock         in   system clock
//   reset         in   synchronous active-high reset
//   din           in   serial WS2812 line, asynchronous to clock
//   pix_valid     out  one-cycle strobe, pix_data/pix_index valid
//   pix_data      out  recovered 24-bit word in data-field order
//   pix_index     out  0-based pixel position within the frame
//   frame_done    out  one-cycle strobe on a latch gap after at least one bit
//   frame_pixels  out  complete pixels in the frame, valid with frame_done
//   err           out  one-cycle strobe on any protocol error
//   synced        out  latch gap seen and no resynchronizing error since

module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int CLK_FREQ   = 20000000,
  parameter int NUM_LEDS   = 256,
  parameter int BIT_THRESH = bit_thresh_cycles(CLK_FREQ),
  parameter int MIN_HIGH   = min_high_cycles(CLK_FREQ),
  parameter int MAX_HIGH   = max_high_cycles(CLK_FREQ),
  parameter int RESET_GAP  = reset_gap_cycles(CLK_FREQ)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              din,
  output logic                              pix_valid,
  output logic [23:0]                       pix_data,
  output logic [$clog2(NUM_LEDS+1)-1:0]     pix_index,
  output logic                              frame_done,
  output logic [$clog2(NUM_LEDS+1)-1:0]     frame_pixels,
  output logic                              err,
  output logic                              synced
);

  localparam int              IW      = $clog2(NUM_LEDS + 1);
  localparam logic [IW-1:0]   PIX_MAX = IW'(NUM_LEDS);

  logic          rise;
  logic          bit_valid;
  logic          bit_val;
  logic          glitch;
  logic          too_long;
  logic          gap;

  rx_state_t     state;
  logic [23:0]   sr;
  logic [23:0]   sr_next;
  logic [4:0]    bit_cnt;
  logic [IW-1:0] pix_cnt;

  ws2812_pulse_meter #(
    .MIN_HIGH   (MIN_HIGH),
    .BIT_THRESH (BIT_THRESH),
    .MAX_HIGH   (MAX_HIGH),
    .RESET_GAP  (RESET_GAP)
  ) u_meter (
    .clock      (clock),
    .reset      (reset),
    .din        (din),
    .rise       (rise),
    .bit_valid  (bit_valid),
    .bit_val    (bit_val),
    .glitch     (glitch),
    .too_long   (too_long),
    .gap        (gap)
  );

  // Wire bits arrive MSB-first.
  assign sr_next = {sr[22:0], bit_val};

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_UNSYNC;
      sr           <= '0;
      bit_cnt      <= '0;
      pix_cnt      <= '0;
      pix_valid    <= 1'b0;
      pix_data     <= '0;
      pix_index    <= '0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      err          <= 1'b0;
      synced       <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      case (state)
        ST_UNSYNC: begin
          if (gap && !rise) begin
            state  <= ST_IDLE;
            synced <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (rise)
            state <= ST_HIGH;
        end
        ST_HIGH: begin
          if (glitch || too_long) begin
            // Framing is lost: discard everything and wait for a latch gap.
            err     <= 1'b1;
            synced  <= 1'b0;
            state   <= ST_UNSYNC;
            sr      <= '0;
            bit_cnt <= '0;
            pix_cnt <= '0;
          end else if (bit_valid) begin
            state <= ST_LOW;
            sr    <= sr_next;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              if (pix_cnt == PIX_MAX) begin
                // More pixels than the strip holds: flag, drop, keep counting frame.
                err <= 1'b1;
              end else begin
                pix_valid <= 1'b1;
                pix_data  <= wire_to_data(sr_next);
                pix_index <= pix_cnt;
                pix_cnt   <= pix_cnt + IW'(1);
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        ST_LOW: begin
          if (rise) begin
            state <= ST_HIGH;
          end else if (gap) begin
            frame_done   <= 1'b1;
            frame_pixels <= pix_cnt;
            if (bit_cnt != 5'd0)
              err <= 1'b1;
            state   <= ST_IDLE;
            sr      <= '0;
            bit_cnt <= '0;
            pix_cnt <= '0;
          end
        end
        default: state <= ST_UNSYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb/tb_ws2812_rx.sv - self-checking bench for ws2812_rx
module tb_ws2812_rx;

  localparam int NUM_LEDS = 2;
  localparam int IW       = $clog2(NUM_LEDS + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          din;
  logic          pix_valid;
  logic [23:0]   pix_data;
  logic [IW-1:0] pix_index;
  logic          frame_done;
  logic [IW-1:0] frame_pixels;
  logic          err;
  logic          synced;

  ws2812_rx #(
    .CLK_FREQ (20000000),
    .NUM_LEDS (NUM_LEDS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .din          (din),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_index    (pix_index),
    .frame_done   (frame_done),
    .frame_pixels (frame_pixels),
    .err          (err),
    .synced       (synced)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [23:0] data;
    int          idx;
  } pix_ev_t;

  pix_ev_t pix_q[$];
  int      fd_px[$];
  int      fd_err[$];
  int      err_total = 0;

  // Event log, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (reset === 1'b0) begin
        if (pix_valid === 1'b1) begin
          pix_ev_t ev;
          ev.data = pix_data;
          ev.idx  = int'(pix_index);
          pix_q.push_back(ev);
        end
        if (frame_done === 1'b1) begin
          fd_px.push_back(int'(frame_pixels));
          fd_err.push_back(int'(err));
        end
        if (err === 1'b1)
          err_total = err_total + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    din = 1'b1;
    repeat (hi) @(negedge clock);
    din = 1'b0;
    repeat (lo) @(negedge clock);
  endtask

  task automatic send_word(input logic [23:0] w, input int w1, input int w0);
    for (int i = 23; i >= 0; i--)
      pulse(w[i] ? w1 : w0, 12);
  endtask

  task automatic gap_wait();
    din = 1'b0;
    repeat (1020) @(negedge clock);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_pix_valid"},    32'(pix_valid),    32'd0);
    check({tag, "_pix_data"},     32'(pix_data),     32'd0);
    check({tag, "_pix_index"},    32'(pix_index),    32'd0);
    check({tag, "_frame_done"},   32'(frame_done),   32'd0);
    check({tag, "_frame_pixels"}, 32'(frame_pixels), 32'd0);
    check({tag, "_err"},          32'(err),          32'd0);
    check({tag, "_synced"},       32'(synced),       32'd0);
  endtask

  task automatic check_pix(input string tag, input int i, input logic [23:0] exp_d, input int exp_i);
    check({tag, "_present"}, 32'(pix_q.size() > i), 32'd1);
    if (pix_q.size() > i) begin
      check({tag, "_data"},  32'(pix_q[i].data), 32'(exp_d));
      check({tag, "_index"}, 32'(pix_q[i].idx),  32'(exp_i));
    end
  endtask

  task automatic check_frame(input string tag, input int i, input int exp_px, input int exp_err);
    check({tag, "_present"}, 32'(fd_px.size() > i), 32'd1);
    if (fd_px.size() > i) begin
      check({tag, "_pixels"},   32'(fd_px[i]),  32'(exp_px));
      check({tag, "_err_same"}, 32'(fd_err[i]), 32'(exp_err));
    end
  endtask

  typedef struct {
    string       name;
    logic [23:0] wire_w;
    int          w1;
    int          w0;
    logic [23:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int p0, f0, e0;

    vecs[0] = '{"nominal",   24'h341256, 14,  7, 24'h123456};
    vecs[1] = '{"thr_12_11", 24'hCDABEF, 12, 11, 24'hABCDEF};
    vecs[2] = '{"max_40",    24'hFFFFFF, 40,  2, 24'hFFFFFF};
    vecs[3] = '{"all_11",    24'h00FFFF, 11,  7, 24'h000000};
    vecs[4] = '{"min_2",     24'h0F0F0F, 14,  2, 24'h0F0F0F};
    vecs[5] = '{"mixed",     24'h800001, 12, 11, 24'h008001};

    reset = 1'b1;
    din   = 1'b0;
    repeat (3) @(negedge clock);
    check_outputs_zero("reset");
    reset = 1'b0;

    repeat (500) @(negedge clock);
    check("unsync_before_gap", 32'(synced), 32'd0);
    repeat (600) @(negedge clock);
    check("synced_after_gap", 32'(synced), 32'd1);

    // Loopback frame with latency check on the first pixel's last bit.
    p0 = pix_q.size(); f0 = fd_px.size(); e0 = err_total;
    for (int i = 23; i >= 1; i--)
      pulse((24'h341256 >> i) & 24'h1 ? 14 : 7, 12);
    din = 1'b1;
    repeat (7) @(negedge clock);
    din = 1'b0;
    @(negedge clock);
    check("lat_edge1", 32'(pix_valid), 32'd0);
    @(negedge clock);
    check("lat_edge2", 32'(pix_valid), 32'd0);
    @(negedge clock);
    check("lat_edge3", 32'(pix_valid), 32'd1);
    check("lat_data",  32'(pix_data),  32'h123456);
    repeat (9) @(negedge clock);
    send_word(24'hCDABEF, 14, 7);
    gap_wait();
    check("loop_npix", 32'(pix_q.size() - p0), 32'd2);
    check_pix("loop_p0", p0, 24'h123456, 0);
    check_pix("loop_p1", p0 + 1, 24'hABCDEF, 1);
    check("loop_nframe", 32'(fd_px.size() - f0), 32'd1);
    check_frame("loop_fd", f0, 2, 0);
    check("loop_err", 32'(err_total - e0), 32'd0);

    // Table of single-pixel frames.
    foreach (vecs[k]) begin
      p0 = pix_q.size(); f0 = fd_px.size(); e0 = err_total;
      send_word(vecs[k].wire_w, vecs[k].w1, vecs[k].w0);
      gap_wait();
      check({vecs[k].name, "_npix"}, 32'(pix_q.size() - p0), 32'd1);
      check_pix(vecs[k].name, p0, vecs[k].exp_data, 0);
      check_frame({vecs[k].name, "_fd"}, f0, 1, 0);
      check({vecs[k].name, "_err"}, 32'(err_total - e0), 32'd0);
    end

    // Glitch: 1-cycle pulse loses sync; data ignored until a gap.
    p0 = pix_q.size(); f0 = fd_px.size(); e0 = err_total;
    pulse(1, 12);
    check("glitch_err", 32'(err_total - e0), 32'd1);
    check("glitch_synced", 32'(synced), 32'd0);
    send_word(24'h341256, 14, 7);
    check("glitch_no_pix", 32'(pix_q.size() - p0), 32'd0);
    gap_wait();
    check("glitch_resync", 32'(synced), 32'd1);
    check("glitch_no_frame", 32'(fd_px.size() - f0), 32'd0);
    check("glitch_err_once", 32'(err_total - e0), 32'd1);

    // Partial frame: 30 bits then latch.
    p0 = pix_q.size(); f0 = fd_px.size(); e0 = err_total;
    send_word(24'h341256, 14, 7);
    repeat (6) pulse(14, 12);
    gap_wait();
    check("part_npix", 32'(pix_q.size() - p0), 32'd1);
    check_pix("part_p0", p0, 24'h123456, 0);
    check_frame("part_fd", f0, 1, 1);
    check("part_err", 32'(err_total - e0), 32'd1);
    check("part_synced", 32'(synced), 32'd1);

    // Stuck high.
    e0 = err_total;
    din = 1'b1;
    repeat (50) @(negedge clock);
    din = 1'b0;
    repeat (5) @(negedge clock);
    check("stuck_err", 32'(err_total - e0), 32'd1);
    check("stuck_synced", 32'(synced), 32'd0);
    gap_wait();
    check("stuck_resync", 32'(synced), 32'd1);

    // Overflow: three pixels into a two-pixel strip.
    p0 = pix_q.size(); f0 = fd_px.size(); e0 = err_total;
    send_word(24'h341256, 14, 7);
    send_word(24'hCDABEF, 14, 7);
    send_word(24'h00FFFF, 14, 7);
    gap_wait();
    check("ovf_npix", 32'(pix_q.size() - p0), 32'd2);
    check_pix("ovf_p1", p0 + 1, 24'hABCDEF, 1);
    check("ovf_err", 32'(err_total - e0), 32'd1);
    check_frame("ovf_fd", f0, 2, 0);
    check("ovf_synced", 32'(synced), 32'd1);

    // Reset mid-pixel.
    repeat (10) pulse(14, 12);
    reset = 1'b1;
    @(negedge clock);
    check_outputs_zero("midrst");
    repeat (3) @(negedge clock);
    reset = 1'b0;
    p0 = pix_q.size(); f0 = fd_px.size(); e0 = err_total;
    repeat (500) @(negedge clock);
    check("midrst_unsync", 32'(synced), 32'd0);
    repeat (600) @(negedge clock);
    check("midrst_synced", 32'(synced), 32'd1);
    send_word(24'h341256, 14, 7);
    send_word(24'hCDABEF, 14, 7);
    gap_wait();
    check("midrst_npix", 32'(pix_q.size() - p0), 32'd2);
    check_pix("midrst_p0", p0, 24'h123456, 0);
    check_pix("midrst_p1", p0 + 1, 24'hABCDEF, 1);
    check_frame("midrst_fd", f0, 2, 0);
    check("midrst_err", 32'(err_total - e0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Receive-side decoder for the WS2812 one-wire pulse stream the LED transmitter drives.
- Recovers 24-bit pixel words, pixel indices and frame boundaries (latch gaps) from a single serial input.
- Used for transmitter loopback checking on the board and for chaining or sniffing a strip's data line.
- Emits a strobed pixel stream with no back-pressure, plus error and frame-done strobes.

Parameters:
- CLK_FREQ, 20000000: system clock in Hz; all timing constants derive from it.
- NUM_LEDS, 256: expected pixels per frame; sets index width and the overflow check.
- BIT_THRESH, $rtoi(CLK_FREQ*0.6e-6) = 12: a high pulse of at least this many cycles decodes as 1, shorter decodes as 0.
- MIN_HIGH, $rtoi(CLK_FREQ*0.1e-6) = 2: a high pulse shorter than this is a glitch.
- MAX_HIGH, $rtoi(CLK_FREQ*2.0e-6) = 40: a high pulse longer than this is an error.
- RESET_GAP, CLK_FREQ/20000 = 1000: low time, in cycles, that constitutes a latch (50 us).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- din  in  1  serial WS2812 line; asynchronous to clock.
- pix_valid  out  1  one-cycle strobe: pix_data and pix_index are valid.
- pix_data  out  24  recovered word in transmitter data-field order.
- pix_index  out  $clog2(NUM_LEDS+1)  0-based position of the pixel in the current frame.
- frame_done  out  1  one-cycle strobe on a latch gap following at least one bit.
- frame_pixels  out  $clog2(NUM_LEDS+1)  complete pixels in the frame; valid with frame_done.
- err  out  1  one-cycle strobe on any protocol error.
- synced  out  1  high once a latch gap has been seen and no error is outstanding.

Behaviour:
- Reset: all outputs 0, FSM enters UNSYNC, all counters 0. Reset mid-frame discards the partial word.
- Input path: 2-flop synchronizer gives din_s; din_d is din_s delayed one cycle. rise = ~din_d & din_s, fall = din_d & ~din_s.
- Counters:
  - hi_cnt counts cycles with din_s high, cleared on rise, saturating at MAX_HIGH+1.
  - lo_cnt counts cycles with din_s low, cleared on fall, saturating at RESET_GAP.
- FSM states: UNSYNC, IDLE, HIGH, LOW.
- UNSYNC:
  - Wait for lo_cnt == RESET_GAP, then go to IDLE with synced=1.
  - Any rise clears lo_cnt and keeps the FSM in UNSYNC.
- IDLE: on rise go to HIGH; bit_cnt, pix_cnt and the shift register are 0.
- HIGH:
  - On fall with hi_cnt < MIN_HIGH: err strobe, go to UNSYNC, drop the partial word.
  - On fall otherwise: shift in (hi_cnt >= BIT_THRESH) MSB-first, go to LOW.
  - If hi_cnt > MAX_HIGH while still high: err strobe, go to UNSYNC.
- LOW:
  - On rise go to HIGH.
  - If lo_cnt reaches RESET_GAP: latch, then go to IDLE.
- Pixel assembly:
  - Wire bytes arrive W0, W1, W2 (W0 first); pix_data = {W1, W0, W2}.
  - This inverts the transmitter's G/R swap, so a loopback returns the original data field.
- Latency: on the fall completing bit 24, pix_valid is registered.
  - It asserts on the 3rd rising edge, counting the edge that first samples din low as edge 1.
  - pix_index = pix_cnt; pix_cnt then increments and bit_cnt wraps 24 -> 0.
- Latch: assert frame_done with frame_pixels = pix_cnt. If bit_cnt != 0, also assert err in the same cycle and drop the partial word.
- Overflow: a pixel completing when pix_cnt == NUM_LEDS is not emitted; err strobes and pix_cnt holds.
- Simultaneous events: a latch and a new rise cannot coincide, because a rise clears lo_cnt first. Reset overrides everything.
- synced drops on any err that returns the FSM to UNSYNC. Partial-frame and overflow errors leave it high.

Decomposition:
- Package ws2812_pkg holds:
  - the shared timing-constant functions (T0H/T1H/BIT_THRESH/RESET_GAP from CLK_FREQ), so the transmitter and receiver cannot drift;
  - the FSM state enum;
  - the byte-reorder function between data-field order and wire order.
- One sub-module, ws2812_pulse_meter: synchronizer, edge detect, hi_cnt/lo_cnt. It outputs bit_valid, bit_val, glitch, too_long and gap.

Test Plan (CLK_FREQ=20 MHz):
1. Loopback: transmitter with NUM_LEDS=2, data {24'h123456, 24'hABCDEF}, after ≥1000 idle cycles -> pix_valid twice with pix_data 123456 (index 0) and ABCDEF (index 1); frame_done with frame_pixels=2; err never asserted.
2. Threshold: high pulses of 11 and 12 cycles -> decoded bits 0 and 1 respectively; pulse of 1 cycle -> err, synced=0, and no pix_valid until the next 1000-cycle low.
3. Partial frame: 30 bits then a 1000-cycle low -> one pix_valid, then frame_done with frame_pixels=1 and err in the same cycle.
4. Stuck-high: din held high for 50 cycles -> err once hi_cnt > 40; synced=0; recovers after a gap.
5. Overflow: NUM_LEDS=2, send 3 pixels -> two pix_valid strobes, then err, frame_pixels=2.
6. Reset mid-pixel (after 10 bits), then a clean frame -> all outputs 0 during reset; no output until a gap, then correct decoding of the new frame.
